// File: rtl/fir_mac_serial.sv
// Serial FIR core: one signed multiply-accumulate per clock over TAPS coefficients.
// A sample comes in on a valid/ready handshake and the result goes out on a valid/ready port.
module fir_mac_serial #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int ACC_W  = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [TAPS*COEF_W-1:0]   coef_flat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic                     busy
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int IDX_W  = $clog2(TAPS);

  generate
    if (TAPS < 2 || ACC_W < PROD_W + $clog2(TAPS)) begin : g_param_chk
      $error("fir_mac_serial: TAPS must be >= 2 and ACC_W >= DATA_W+COEF_W+clog2(TAPS)");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                        state;
  logic [TAPS-1:0][DATA_W-1:0]   xd;
  logic [TAPS-1:0][COEF_W-1:0]   cc;
  logic [IDX_W-1:0]              idx;
  logic [ACC_W-1:0]              acc;
  logic [ACC_W-1:0]              acc_nxt;
  logic signed [PROD_W-1:0]      prod;

  // The rule on ACC_W guarantees room for the sign-extension bits.
  always_comb begin
    prod    = $signed(xd[idx]) * $signed(cc[idx]);
    acc_nxt = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      xd        <= '0;
      cc        <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xd    <= {xd[TAPS-2:0], in_data};
          cc    <= coef_flat;
          acc   <= '0;
          idx   <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc_nxt;
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(TAPS-1)) begin
            out_data  <= acc_nxt;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_serial.sv
// Scenario bench for fir_mac_serial: a reference sum pushed to a queue per accepted sample,
// popped and compared when out_valid appears.
module tb_fir_mac_serial;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 4;
  localparam int ACC_W  = 18;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data = '0;
  logic [TAPS*COEF_W-1:0] coef_flat = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [ACC_W-1:0]       out_data;
  logic                   busy;

  int hist[TAPS];
  int exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  fir_mac_serial #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_flat(coef_flat), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [TAPS*COEF_W-1:0] pack(input int c0, input int c1, input int c2, input int c3);
    return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  function automatic int sext_out(input logic [ACC_W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (hist[k]) hist[k] = 0;
    exp_q.delete();
  endtask

  // Drives one sample through the handshake and records the reference result.
  task automatic send(input int d, input logic [TAPS*COEF_W-1:0] cf);
    int n = 0;
    int sum = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_wait: in_ready=%0b required 1 within 40 cycles", in_ready);
    end
    in_valid = 1'b1; in_data = 8'(d); coef_flat = cf;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = TAPS-1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = d;
    for (int k = 0; k < TAPS; k++) sum += hist[k] * int'($signed(cf[k*COEF_W +: COEF_W]));
    exp_q.push_back(sum);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 3*TAPS) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", sext_out(out_data)); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_impulse();
    int xs[4] = '{1, 0, 0, 0};
    int lat, e;
    do_reset(); out_ready = 1'b1;
    foreach (xs[i]) begin
      send(xs[i], pack(1, 2, 3, 4));
      wait_out(lat);
      e = exp_q.pop_front();
      n_checks++; if (lat !== TAPS) begin n_fail++; $display("FAIL impulse_latency[%0d]: got %0d want %0d", i, lat, TAPS); end
      n_checks++; if (sext_out(out_data) !== e) begin n_fail++; $display("FAIL impulse_data[%0d]: got %0d want %0d", i, sext_out(out_data), e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_extremes();
    int lat, e;
    do_reset(); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(-128, pack(-128, -128, -128, -128));
      wait_out(lat);
      e = exp_q.pop_front();
      n_checks++; if (e !== 16384*(i+1)) begin n_fail++; $display("FAIL extremes_model[%0d]: got %0d want %0d", i, e, 16384*(i+1)); end
      n_checks++; if (sext_out(out_data) !== e) begin n_fail++; $display("FAIL extremes_data[%0d]: got %0d want %0d", i, sext_out(out_data), e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mixed_sign();
    int xs[3] = '{5, 7, -3};
    int want[3] = '{5, 2, -10};
    int lat, e;
    do_reset(); out_ready = 1'b1;
    foreach (xs[i]) begin
      send(xs[i], pack(1, -1, 0, 0));
      wait_out(lat);
      e = exp_q.pop_front();
      n_checks++; if (lat !== TAPS) begin n_fail++; $display("FAIL mixed_latency[%0d]: got %0d want %0d", i, lat, TAPS); end
      n_checks++; if (sext_out(out_data) !== want[i] || e !== want[i]) begin
        n_fail++; $display("FAIL mixed_data[%0d]: got %0d want %0d", i, sext_out(out_data), want[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat, e;
    do_reset(); out_ready = 1'b0;
    send(3, pack(1, 2, 3, 4));
    wait_out(lat);
    e = exp_q.pop_front();
    n_checks++; if (lat !== TAPS) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, TAPS); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, out_valid); end
      n_checks++; if (sext_out(out_data) !== e) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, sext_out(out_data), e); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); end
      in_valid = 1'b1; in_data = 8'(99);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %0b want 0", out_valid); end
    n_checks++; if (sext_out(out_data) !== e) begin n_fail++; $display("FAIL bp_retain_data: got %0d want %0d", sext_out(out_data), e); end
    // The ignored 99s must not have entered the delay line.
    send(0, pack(1, 2, 3, 4));
    wait_out(lat);
    e = exp_q.pop_front();
    n_checks++; if (sext_out(out_data) !== e) begin n_fail++; $display("FAIL bp_no_consume: got %0d want %0d", sext_out(out_data), e); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mac();
    int want[4] = '{1, 2, 3, 4};
    int lat, e;
    do_reset(); out_ready = 1'b1;
    send(9, pack(1, 2, 3, 4));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (hist[k]) hist[k] = 0;
    exp_q.delete();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0b want 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      send((i == 0) ? 1 : 0, pack(1, 2, 3, 4));
      wait_out(lat);
      e = exp_q.pop_front();
      n_checks++; if (lat !== TAPS) begin n_fail++; $display("FAIL midrst_latency[%0d]: got %0d want %0d", i, lat, TAPS); end
      n_checks++; if (sext_out(out_data) !== want[i] || e !== want[i]) begin
        n_fail++; $display("FAIL midrst_data[%0d]: got %0d want %0d", i, sext_out(out_data), want[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_coef_change();
    int lat, e;
    do_reset(); out_ready = 1'b1;
    send(2, pack(1, 2, 3, 4));
    coef_flat = '0;
    wait_out(lat);
    e = exp_q.pop_front();
    n_checks++; if (sext_out(out_data) !== e) begin n_fail++; $display("FAIL coef_hold0: got %0d want %0d", sext_out(out_data), e); end
    @(posedge clk); #1;
    send(-6, pack(-3, 5, 7, 1));
    coef_flat = pack(100, 100, 100, 100);
    wait_out(lat);
    e = exp_q.pop_front();
    n_checks++; if (lat !== TAPS) begin n_fail++; $display("FAIL coef_latency: got %0d want %0d", lat, TAPS); end
    n_checks++; if (sext_out(out_data) !== e) begin n_fail++; $display("FAIL coef_hold1: got %0d want %0d", sext_out(out_data), e); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_extremes();
    test_mixed_sign();
    test_backpressure();
    test_reset_mid_mac();
    test_coef_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
